// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with runtime frame format.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   tx_data/tx_valid/tx_ready - push interface into the transmit FIFO
//   data_bits_sel   - 00..11 selects 5..8 data bits
//   parity_sel      - 00 none, 01 even, 10 odd, 11 mark
//   stop2           - 1 selects two stop bits
//   baud_div        - clocks per bit, 0 selects CLK_FREQ/BAUD_RATE, clamped to >= 2
//   tx_serial       - registered serial line, idles high
//   tx_busy/tx_done - frame in progress / one-cycle end-of-frame pulse
//   fifo_count      - words currently held in the FIFO
//
// Frame format and divisor are captured when a word is popped, so changes on
// the config inputs only ever apply to the next frame.
module uart_tx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [1:0]                    data_bits_sel,
  input  logic [1:0]                    parity_sel,
  input  logic                          stop2,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(CLK_FREQ / BAUD_RATE);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  // ---------------- transmit FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_nempty;

  // Depth is a power of two, so "count < depth" is just the count MSB clear.
  assign tx_ready    = ~count[AW];
  assign fifo_nempty = (count != '0);
  assign push        = tx_valid & tx_ready;
  assign fifo_count  = count;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= tx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0] cnt, div_q, div_raw, div_eff;
  logic [2:0]       idx;
  logic [7:0]       sh, mask;
  logic [1:0]       dbits_q, par_q;
  logic             stop2_q, par_bit_q, par_bit;
  logic             bit_end, last_data, last_stop, frame_end, load;
  logic             ser_nxt, busy_nxt, done_nxt;

  assign div_raw   = (baud_div != '0) ? baud_div : DEF_DIV;
  assign div_eff   = (div_raw < TWO) ? TWO : div_raw;
  assign bit_end   = (state != IDLE) && (cnt == '0);
  assign last_data = (idx == ({1'b0, dbits_q} + 3'd4));
  assign last_stop = (idx == {2'b00, stop2_q});
  assign frame_end = (state == STOP) && bit_end && last_stop;
  // A word is taken either from idle or right at the end of a frame, which
  // gives back-to-back frames with no idle gap.
  assign load      = fifo_nempty && ((state == IDLE) || frame_end);
  assign pop       = load;

  // Parity covers only the bits that will actually be sent.
  assign mask = 8'hFF >> (2'd3 - data_bits_sel);
  always_comb begin
    case (parity_sel)
      2'b01:   par_bit =  ^(mem[rd_ptr] & mask);
      2'b10:   par_bit = ~^(mem[rd_ptr] & mask);
      default: par_bit = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_nempty) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_data) state_nxt = (par_q != 2'b00) ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (frame_end) state_nxt = fifo_nempty ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs (next values of the registered line, busy and done)
  always_comb begin
    ser_nxt  = tx_serial;
    busy_nxt = tx_busy;
    done_nxt = frame_end;
    if (load) begin
      ser_nxt  = 1'b0;
      busy_nxt = 1'b1;
    end else if (bit_end) begin
      case (state)
        START:   ser_nxt = sh[0];
        DATA:    ser_nxt = !last_data ? sh[0] : ((par_q != 2'b00) ? par_bit_q : 1'b1);
        PARITY:  ser_nxt = 1'b1;
        STOP:    if (last_stop) begin
                   ser_nxt  = 1'b1;
                   busy_nxt = 1'b0;
                 end
        default: ;
      endcase
    end
  end

  // datapath: bit counter, shifter, latched frame config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      div_q     <= '0;
      idx       <= '0;
      sh        <= '0;
      dbits_q   <= '0;
      par_q     <= '0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_serial <= ser_nxt;
      tx_busy   <= busy_nxt;
      tx_done   <= done_nxt;
      if (load) begin
        cnt       <= div_eff - ONE;
        div_q     <= div_eff;
        idx       <= '0;
        sh        <= mem[rd_ptr];
        dbits_q   <= data_bits_sel;
        par_q     <= parity_sel;
        stop2_q   <= stop2;
        par_bit_q <= par_bit;
      end else if (bit_end) begin
        cnt <= div_q - ONE;
        case (state)
          START: sh <= sh >> 1;
          DATA:  if (!last_data) begin
                   sh  <= sh >> 1;
                   idx <= idx + 3'd1;
                 end else begin
                   idx <= '0;
                 end
          STOP:  idx <= idx + 3'd1;
          default: ;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param. Each accepted push
// queues the expected frame (bits, length, clocks per bit); a line monitor
// follows every frame clock by clock and compares against the queue head.
module tb_uart_tx_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  data_bits_sel, parity_sel;
  logic        stop2;
  logic [15:0] baud_div;
  logic        tx_serial, tx_busy, tx_done;
  logic [3:0]  fifo_count;

  always #5 clk = ~clk;

  uart_tx_param #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .FIFO_DEPTH(8), .DIV_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_bits_sel(data_bits_sel), .parity_sel(parity_sel),
    .stop2(stop2), .baud_div(baud_div), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [11:0] bits;
    int          len;
    int          div;
  } frame_t;

  frame_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0, t1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame for a word under the current config inputs.
  function automatic frame_t mk(input logic [7:0] d);
    frame_t f;
    int     n;
    logic   p;
    n = 5 + int'(data_bits_sel);
    f.bits = '1;
    f.bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[1+i] = d[i];
      p ^= d[i];
    end
    f.len = 1 + n;
    if (parity_sel != 2'b00) begin
      f.bits[f.len] = (parity_sel == 2'b01) ? p : (parity_sel == 2'b10) ? ~p : 1'b1;
      f.len++;
    end
    f.len += stop2 ? 2 : 1;
    // CLK_FREQ/BAUD_RATE = 4 for this bench
    f.div = (baud_div == 16'd0) ? 4 : (baud_div < 16'd2) ? 2 : int'(baud_div);
    return f;
  endfunction

  // Follows one frame starting at the current negedge (start bit seen).
  task automatic run_frame();
    frame_t      e;
    logic [11:0] obs;
    logic        glitch;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 32'd1, 32'd0);
      for (int k = 0; k < 200 && tx_serial === 1'b0; k++) @(negedge clk);
      return;
    end
    e = sb.pop_front();
    obs = '1;
    glitch = 1'b0;
    for (int b = 0; b < e.len; b++) begin
      for (int c = 0; c < e.div; c++) begin
        if (b != 0 || c != 0) begin
          @(negedge clk);
          if (tx_done !== 1'b0) glitch = 1'b1;
        end
        if (!rst_n) return;
        if (tx_serial !== e.bits[b] || tx_busy !== 1'b1) glitch = 1'b1;
        if (c == e.div / 2) obs[b] = tx_serial;
      end
    end
    @(negedge clk);
    if (!rst_n) return;
    chk("frame_bits", 32'(obs), 32'(e.bits));
    chk("frame_timing", 32'(glitch), 32'd0);
    chk("done_pulse", 32'(tx_done), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (rst_n && tx_serial === 1'b0) run_frame();
    end
  end

  task automatic cfg(input logic [1:0] db, input logic [1:0] ps, input logic s2, input logic [15:0] bd);
    data_bits_sel = db;
    parity_sel    = ps;
    stop2         = s2;
    baud_div      = bd;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk("push_timeout", 32'd1, 32'd0);
      tx_valid = 1'b0;
      return;
    end
    sb.push_back(mk(d));
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tx_busy || sb.size() != 0 || fifo_count != 4'd0) && n < 5000);
    if (n >= 5000) chk("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    cfg(2'd3, 2'd0, 1'b0, 16'd4);
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(tx_serial), 32'd1);
    chk("rst_busy",   32'(tx_busy),   32'd0);
    chk("rst_done",   32'(tx_done),   32'd0);
    chk("rst_ready",  32'(tx_ready),  32'd1);
    chk("rst_count",  32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, 0xA5, with start latency
    push(8'hA5);
    chk("lat_edge_n", 32'(tx_serial), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_edge_n1", 32'(tx_serial), 32'd0);
    chk("busy_start", 32'(tx_busy), 32'd1);
    wait_idle();
    chk("busy_idle", 32'(tx_busy), 32'd0);

    // 7E2 0x41, 5O1 / 5M1 0x1F, default and clamped divisors
    cfg(2'd2, 2'd1, 1'b1, 16'd4); push(8'h41); wait_idle();
    cfg(2'd0, 2'd2, 1'b0, 16'd4); push(8'h1F); wait_idle();
    cfg(2'd0, 2'd3, 1'b0, 16'd4); push(8'h1F); wait_idle();
    cfg(2'd3, 2'd0, 1'b0, 16'd0); push(8'h5A); wait_idle();
    cfg(2'd3, 2'd0, 1'b0, 16'd1); push(8'hC3); wait_idle();

    // config change mid-frame only hits the next frame
    cfg(2'd3, 2'd0, 1'b0, 16'd4); push(8'h3C);
    repeat (3) @(negedge clk);
    cfg(2'd0, 2'd3, 1'b1, 16'd6);
    wait_idle();
    push(8'h15); wait_idle();

    // burst: one in flight, FIFO filled to 8, ninth held by the producer
    cfg(2'd3, 2'd0, 1'b0, 16'd4);
    fork
      begin : prod
        push(8'h00);
        t0 = cyc;
        for (int i = 1; i <= 8; i++) push(8'(i * 17));
        @(negedge clk);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ready", 32'(tx_ready), 32'd0);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("held_count", 32'(fifo_count), 32'd8);
        push(8'hEE);
      end
      begin : cons
        int dn, n;
        dn = 0;
        n  = 0;
        while (dn < 10 && n < 1000) begin
          @(negedge clk);
          n++;
          if (tx_done) begin
            dn++;
            if (dn < 10) chk("b2b_busy", 32'(tx_busy), 32'd1);
          end
        end
        t1 = cyc;
        chk("burst_done_cnt", 32'(dn), 32'd10);
      end
    join
    chk("burst_span", 32'(t1 - t0), 32'd401);
    wait_idle();

    // reset mid-DATA with 3 words queued
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    repeat (8) @(negedge clk);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_serial", 32'(tx_serial), 32'd1);
    chk("mid_rst_count",  32'(fifo_count), 32'd0);
    chk("mid_rst_busy",   32'(tx_busy),   32'd0);
    chk("mid_rst_ready",  32'(tx_ready),  32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || fifo_count != 4'd0) act++;
    end
    chk("post_rst_quiet", 32'(act), 32'd0);
    push(8'h99);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
